// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE. Operands hop right/down through one register
// stage each. The local accumulator gathers top*left for exactly k_len
// valid-qualified products, and a small FSM tracks the tile. The finished sum
// is drained through a column psum shift chain.
module pe_mac_os #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,   // must be >= 2*DATA_WIDTH
    parameter int SIGNED     = 1,    // 1: two's complement, 0: unsigned
    parameter int SATURATE   = 1,    // 1: clamp on overflow, 0: wrap
    parameter int K_WIDTH    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [K_WIDTH-1:0]    k_len_i,
    input  logic [DATA_WIDTH-1:0] top_in_i,
    input  logic                  top_valid_i,
    input  logic [DATA_WIDTH-1:0] left_in_i,
    input  logic                  left_valid_i,
    output logic [DATA_WIDTH-1:0] right_out_o,
    output logic                  right_valid_o,
    output logic [DATA_WIDTH-1:0] bottom_out_o,
    output logic                  bottom_valid_o,
    input  logic                  shift_en_i,
    input  logic [ACC_WIDTH-1:0]  psum_in_i,
    output logic [ACC_WIDTH-1:0]  psum_out_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    localparam int   PW  = 2 * DATA_WIDTH;
    localparam int   EW  = ACC_WIDTH + 1;
    localparam logic SGN = (SIGNED != 0);
    localparam logic SAT = (SATURATE != 0);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_e;

    state_e                state_q, state_d;
    logic [K_WIDTH-1:0]    cnt_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic                  ovf_q;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] right_q, bottom_q;
    logic                  right_vld_q, bottom_vld_q;

    logic                  mac_fire;
    logic [PW-1:0]         top_x, left_x, prod;
    logic [EW-1:0]         prod_ext, acc_ext, sum;
    logic                  ovf_now;
    logic [ACC_WIDTH-1:0]  sat_val, acc_mac;

    // State register: the tile FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next state: start overrides everything; the last counted MAC closes the tile
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (start_i) begin
            state_d = (k_len_i != '0) ? S_ACCUM : S_HOLD;
            done_d  = (k_len_i == '0);
        end else if (mac_fire && cnt_q == K_WIDTH'(1)) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
        end
    end

    // FSM outputs: busy while accumulating, MAC only when both operands are valid
    always_comb begin
        busy_o   = (state_q == S_ACCUM);
        mac_fire = (state_q == S_ACCUM) && top_valid_i && left_valid_i;
    end

    // Multiply-accumulate at ACC_WIDTH+1 bits with overflow detect and clamp/wrap.
    // Operands are pre-extended to 2*DATA_WIDTH so the low half of an unsigned
    // multiply equals the signed product as well.
    always_comb begin
        top_x    = {{DATA_WIDTH{SGN & top_in_i[DATA_WIDTH-1]}}, top_in_i};
        left_x   = {{DATA_WIDTH{SGN & left_in_i[DATA_WIDTH-1]}}, left_in_i};
        prod     = top_x * left_x;
        prod_ext = {{(EW-PW){SGN & prod[PW-1]}}, prod};
        acc_ext  = {SGN & acc_q[ACC_WIDTH-1], acc_q};
        sum      = acc_ext + prod_ext;
        if (SGN) begin
            ovf_now = (acc_q[ACC_WIDTH-1] == prod[PW-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
            sat_val = acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            ovf_now = sum[ACC_WIDTH];
            sat_val = '1;
        end
        acc_mac = (ovf_now && SAT) ? sat_val : sum[ACC_WIDTH-1:0];
    end

    // Datapath: forwarding registers, accumulator, tile counter, sticky overflow
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            right_q      <= '0;
            right_vld_q  <= 1'b0;
            bottom_q     <= '0;
            bottom_vld_q <= 1'b0;
            acc_q        <= '0;
            ovf_q        <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            right_q      <= left_in_i;
            right_vld_q  <= left_valid_i;
            bottom_q     <= top_in_i;
            bottom_vld_q <= top_valid_i;
            done_q       <= done_d;
            if (start_i) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
                cnt_q <= k_len_i;
            end else if (mac_fire) begin
                acc_q <= acc_mac;
                ovf_q <= ovf_q | ovf_now;
                cnt_q <= cnt_q - K_WIDTH'(1);
            end else if (shift_en_i && state_q != S_ACCUM) begin
                acc_q <= psum_in_i;
            end
        end
    end

    assign right_out_o    = right_q;
    assign right_valid_o  = right_vld_q;
    assign bottom_out_o   = bottom_q;
    assign bottom_valid_o = bottom_vld_q;
    assign psum_out_o     = acc_q;
    assign done_o         = done_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_pe_mac_os.sv
// Bench for pe_mac_os: five PEs (two chained 32-bit signed-saturating, three
// 16-bit in signed-sat / signed-wrap / unsigned-sat flavours) against a
// range-based arithmetic model, plus hand-computed literal expectations.
module tb_pe_mac_os;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        st [N];
    logic [15:0] kl [N];
    logic [7:0]  tp [N];
    logic        tv [N];
    logic [7:0]  lf [N];
    logic        lv [N];
    logic        sh [N];
    logic [31:0] ext_psum = 32'h55;

    logic [7:0]  ro [N];
    logic [7:0]  bo [N];
    logic        rv [N], bv [N], by [N], dn [N], ov [N];
    logic [31:0] ps [N];
    logic [15:0] ps2, ps3, ps4;

    assign ps[2] = {16'h0, ps2};
    assign ps[3] = {16'h0, ps3};
    assign ps[4] = {16'h0, ps4};

    int aw  [N] = '{32, 32, 16, 16, 16};
    bit sgn [N] = '{1, 1, 1, 1, 0};
    bit sat [N] = '{1, 1, 1, 0, 1};

    int errors = 0;
    int checks = 0;

    // 0: lower PE of the chain, 1: upper PE feeding it
    pe_mac_os u_lo (.clk_i(clk), .rst_ni(rst_n), .start_i(st[0]), .k_len_i(kl[0]),
        .top_in_i(tp[0]), .top_valid_i(tv[0]), .left_in_i(lf[0]), .left_valid_i(lv[0]),
        .right_out_o(ro[0]), .right_valid_o(rv[0]), .bottom_out_o(bo[0]), .bottom_valid_o(bv[0]),
        .shift_en_i(sh[0]), .psum_in_i(ps[1]), .psum_out_o(ps[0]),
        .busy_o(by[0]), .done_o(dn[0]), .ovf_o(ov[0]));
    pe_mac_os u_up (.clk_i(clk), .rst_ni(rst_n), .start_i(st[1]), .k_len_i(kl[1]),
        .top_in_i(tp[1]), .top_valid_i(tv[1]), .left_in_i(lf[1]), .left_valid_i(lv[1]),
        .right_out_o(ro[1]), .right_valid_o(rv[1]), .bottom_out_o(bo[1]), .bottom_valid_o(bv[1]),
        .shift_en_i(sh[1]), .psum_in_i(ext_psum), .psum_out_o(ps[1]),
        .busy_o(by[1]), .done_o(dn[1]), .ovf_o(ov[1]));
    pe_mac_os #(.ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) u_ssat (.clk_i(clk), .rst_ni(rst_n),
        .start_i(st[2]), .k_len_i(kl[2]),
        .top_in_i(tp[2]), .top_valid_i(tv[2]), .left_in_i(lf[2]), .left_valid_i(lv[2]),
        .right_out_o(ro[2]), .right_valid_o(rv[2]), .bottom_out_o(bo[2]), .bottom_valid_o(bv[2]),
        .shift_en_i(sh[2]), .psum_in_i(16'h0), .psum_out_o(ps2),
        .busy_o(by[2]), .done_o(dn[2]), .ovf_o(ov[2]));
    pe_mac_os #(.ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) u_swrap (.clk_i(clk), .rst_ni(rst_n),
        .start_i(st[3]), .k_len_i(kl[3]),
        .top_in_i(tp[3]), .top_valid_i(tv[3]), .left_in_i(lf[3]), .left_valid_i(lv[3]),
        .right_out_o(ro[3]), .right_valid_o(rv[3]), .bottom_out_o(bo[3]), .bottom_valid_o(bv[3]),
        .shift_en_i(sh[3]), .psum_in_i(16'h0), .psum_out_o(ps3),
        .busy_o(by[3]), .done_o(dn[3]), .ovf_o(ov[3]));
    pe_mac_os #(.ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)) u_usat (.clk_i(clk), .rst_ni(rst_n),
        .start_i(st[4]), .k_len_i(kl[4]),
        .top_in_i(tp[4]), .top_valid_i(tv[4]), .left_in_i(lf[4]), .left_valid_i(lv[4]),
        .right_out_o(ro[4]), .right_valid_o(rv[4]), .bottom_out_o(bo[4]), .bottom_valid_o(bv[4]),
        .shift_en_i(sh[4]), .psum_in_i(16'h0), .psum_out_o(ps4),
        .busy_o(by[4]), .done_o(dn[4]), .ovf_o(ov[4]));

    // ---------------- behavioural model ----------------
    // st: 0 idle, 1 accumulating, 2 holding. acc kept as a true integer value.
    typedef struct {
        longint acc; bit ovf; int st; longint cnt; bit done;
        bit [7:0] rd; bit [7:0] bd; bit rv; bit bv;
    } mdl_t;
    mdl_t m  [N];
    mdl_t nx [N];

    function automatic mdl_t step(mdl_t c, int i, longint pin);
        mdl_t n = c;
        longint p, s, mx, mn, md;
        n.rd = lf[i]; n.rv = lv[i]; n.bd = tp[i]; n.bv = tv[i]; n.done = 1'b0;
        md = longint'(1) << aw[i];
        if (sgn[i]) begin mx = md / 2 - 1; mn = -(md / 2); end
        else        begin mx = md - 1;     mn = 0;         end
        if (st[i]) begin
            n.acc = 0; n.ovf = 1'b0; n.cnt = longint'(kl[i]);
            if (kl[i] == 16'd0) begin n.st = 2; n.done = 1'b1; end
            else n.st = 1;
        end else if (c.st == 1 && tv[i] && lv[i]) begin
            if (sgn[i]) p = longint'($signed(tp[i])) * longint'($signed(lf[i]));
            else        p = longint'(tp[i]) * longint'(lf[i]);
            s = c.acc + p;
            if (s > mx || s < mn) begin
                n.ovf = 1'b1;
                if (sat[i]) s = (s > mx) ? mx : mn;
                else begin
                    s = s & (md - 1);
                    if (sgn[i] && s > mx) s = s - md;
                end
            end
            n.acc = s;
            n.cnt = c.cnt - 1;
            if (n.cnt == 0) begin n.st = 2; n.done = 1'b1; end
        end else if (c.st != 1 && sh[i]) begin
            s = pin & (md - 1);
            if (sgn[i] && s > mx) s = s - md;
            n.acc = s;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m[i] = '{default: 0};
        end else begin
            for (int i = 0; i < N; i++)
                nx[i] = step(m[i], i, (i == 0) ? m[1].acc : (i == 1) ? longint'(ext_psum) : 0);
            m = nx;
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all PEs against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            longint mk;
            mk = (longint'(1) << aw[i]) - 1;
            chk("psum",  i, 64'(ps[i]) & 64'(mk), 64'(m[i].acc & mk));
            chk("busy",  i, 64'(by[i]), 64'(m[i].st == 1));
            chk("done",  i, 64'(dn[i]), 64'(m[i].done));
            chk("ovf",   i, 64'(ov[i]), 64'(m[i].ovf));
            chk("rdata", i, 64'(ro[i]), 64'(m[i].rd));
            chk("rvld",  i, 64'(rv[i]), 64'(m[i].rv));
            chk("bdata", i, 64'(bo[i]), 64'(m[i].bd));
            chk("bvld",  i, 64'(bv[i]), 64'(m[i].bv));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input bit [N-1:0] msk, input bit s, input int k, input int t,
                       input bit tvv, input int l, input bit lvv, input bit shv);
        for (int i = 0; i < N; i++) if (msk[i]) begin
            st[i] = s; kl[i] = 16'(k); tp[i] = 8'(t); tv[i] = tvv;
            lf[i] = 8'(l); lv[i] = lvv; sh[i] = shv;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            st[i] = 1'b0; tv[i] = 1'b0; lv[i] = 1'b0; sh[i] = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            st[i] = 0; kl[i] = 0; tp[i] = 0; tv[i] = 0; lf[i] = 0; lv[i] = 0; sh[i] = 0;
        end
        @(negedge clk); @(negedge clk);
        chk("rst_psum", 0, 64'(ps[0]), 64'd0);
        chk("rst_busy", 0, 64'(by[0]), 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: basic tile of three
        drv(5'b00001, 1, 3, 0, 0, 0, 0, 0);
        chk("t1_busy", 0, 64'(by[0]), 64'd1);
        drv(5'b00001, 0, 0, 2, 1, 3, 1, 0); chk("t1_p0", 0, 64'(ps[0]), 64'd6);
        drv(5'b00001, 0, 0, 4, 1, 5, 1, 0); chk("t1_p1", 0, 64'(ps[0]), 64'd26);
        drv(5'b00001, 0, 0, 1, 1, 1, 1, 0); chk("t1_p2", 0, 64'(ps[0]), 64'd27);
        chk("t1_done", 0, 64'(dn[0]), 64'd1);
        @(negedge clk);
        chk("t1_done0", 0, 64'(dn[0]), 64'd0);
        chk("t1_busy0", 0, 64'(by[0]), 64'd0);

        // 2: signed extremes
        drv(5'b00001, 1, 3, 0, 0, 0, 0, 0);
        drv(5'b00001, 0, 0, 8'h80, 1, 8'h80, 1, 0); chk("t2_p0", 0, 64'(ps[0]), 64'd16384);
        drv(5'b00001, 0, 0, 8'h80, 1, 8'h80, 1, 0); chk("t2_p1", 0, 64'(ps[0]), 64'd32768);
        drv(5'b00001, 0, 0, 8'h7f, 1, 8'h80, 1, 0); chk("t2_p2", 0, 64'(ps[0]), 64'd16512);
        chk("t2_ovf", 0, 64'(ov[0]), 64'd0);

        // 3: one-sided valids do not count
        drv(5'b00001, 1, 1, 0, 0, 0, 0, 0);
        drv(5'b00001, 0, 0, 3, 1, 5, 0, 0);
        chk("t3_p0", 0, 64'(ps[0]), 64'd0); chk("t3_bv", 0, 64'(bv[0]), 64'd1); chk("t3_rv", 0, 64'(rv[0]), 64'd0);
        drv(5'b00001, 0, 0, 3, 0, 5, 1, 0);
        chk("t3_p1", 0, 64'(ps[0]), 64'd0); chk("t3_rv1", 0, 64'(rv[0]), 64'd1); chk("t3_bv1", 0, 64'(bv[0]), 64'd0);
        drv(5'b00001, 0, 0, 3, 1, 5, 1, 0);
        chk("t3_p2", 0, 64'(ps[0]), 64'd15); chk("t3_done", 0, 64'(dn[0]), 64'd1);

        // 4: 16-bit overflow behaviour in three flavours
        drv(5'b11100, 1, 3, 0, 0, 0, 0, 0);
        repeat (3) drv(5'b11100, 0, 0, 127, 1, 127, 1, 0);
        chk("t4_sat",  2, 64'(ps[2]), 64'h7fff); chk("t4_sov", 2, 64'(ov[2]), 64'd1);
        chk("t4_wrap", 3, 64'(ps[3]), 64'hbd03); chk("t4_wov", 3, 64'(ov[3]), 64'd1);
        chk("t4_uns",  4, 64'(ps[4]), 64'hbd03); chk("t4_uov", 4, 64'(ov[4]), 64'd0);
        drv(5'b11100, 1, 2, 0, 0, 0, 0, 0);
        repeat (2) drv(5'b11100, 0, 0, 255, 1, 255, 1, 0);
        chk("t4_usat", 4, 64'(ps[4]), 64'hffff); chk("t4_usov", 4, 64'(ov[4]), 64'd1);
        chk("t4_sm1",  2, 64'(ps[2]), 64'd2);    chk("t4_sov0", 2, 64'(ov[2]), 64'd0);
        drv(5'b11100, 1, 3, 0, 0, 0, 0, 0);
        repeat (3) drv(5'b11100, 0, 0, 127, 1, 8'h80, 1, 0);
        chk("t4_smin", 2, 64'(ps[2]), 64'h8000);
        chk("t4_wneg", 3, 64'(ps[3]), 64'h4180);
        chk("t4_ubig", 4, 64'(ps[4]), 64'hbe80);

        // 5: psum chain drain, then shift ignored while accumulating
        drv(5'b00001, 1, 1, 0, 0, 0, 0, 0); drv(5'b00001, 0, 0, 6, 1, 7, 1, 0);
        drv(5'b00010, 1, 1, 0, 0, 0, 0, 0); drv(5'b00010, 0, 0, 9, 1, 10, 1, 0);
        chk("t5_a", 0, 64'(ps[0]), 64'd42);
        drv(5'b00011, 0, 0, 0, 0, 0, 0, 1); chk("t5_b", 0, 64'(ps[0]), 64'd90);
        chk("t5_up", 1, 64'(ps[1]), 64'h55);
        drv(5'b00011, 0, 0, 0, 0, 0, 0, 1); chk("t5_c", 0, 64'(ps[0]), 64'h55);
        drv(5'b00001, 1, 2, 0, 0, 0, 0, 0); drv(5'b00001, 0, 0, 2, 1, 2, 1, 0);
        drv(5'b00001, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_acc", 0, 64'(ps[0]), 64'd4); chk("t5_busy", 0, 64'(by[0]), 64'd1);

        // 6: empty tile, restart mid-tile, async reset mid-tile
        drv(5'b00001, 1, 0, 0, 0, 0, 0, 0);
        chk("t6_done", 0, 64'(dn[0]), 64'd1); chk("t6_p", 0, 64'(ps[0]), 64'd0);
        chk("t6_busy", 0, 64'(by[0]), 64'd0);
        @(negedge clk);
        chk("t6_done0", 0, 64'(dn[0]), 64'd0);
        drv(5'b00001, 1, 3, 0, 0, 0, 0, 0); drv(5'b00001, 0, 0, 5, 1, 5, 1, 0);
        chk("t6_25", 0, 64'(ps[0]), 64'd25);
        drv(5'b00001, 1, 2, 9, 1, 9, 1, 0);
        chk("t6_clr", 0, 64'(ps[0]), 64'd0); chk("t6_busy1", 0, 64'(by[0]), 64'd1);
        drv(5'b00001, 0, 0, 1, 1, 2, 1, 0);
        chk("t6_r0", 0, 64'(ps[0]), 64'd2); chk("t6_nd", 0, 64'(dn[0]), 64'd0);
        drv(5'b00001, 0, 0, 3, 1, 4, 1, 0);
        chk("t6_r1", 0, 64'(ps[0]), 64'd14); chk("t6_rd", 0, 64'(dn[0]), 64'd1);
        drv(5'b00001, 1, 5, 0, 0, 0, 0, 0); drv(5'b00001, 0, 0, 10, 1, 10, 1, 0);
        chk("t6_100", 0, 64'(ps[0]), 64'd100);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_psum", 0, 64'(ps[0]), 64'd0); chk("ar_busy", 0, 64'(by[0]), 64'd0);
        chk("ar_rv",   0, 64'(rv[0]), 64'd0); chk("ar_ro",   0, 64'(ro[0]), 64'd0);
        chk("ar_bv",   0, 64'(bv[0]), 64'd0); chk("ar_done", 0, 64'(dn[0]), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        drv(5'b00001, 1, 1, 0, 0, 0, 0, 0); drv(5'b00001, 0, 0, 3, 1, 3, 1, 0);
        chk("rec_p", 0, 64'(ps[0]), 64'd9);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
